// File: rtl/nvram_ioctl_port.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_ioctl_port
//  Description : HPS ioctl service port for the high-score NVRAM. Returns
//                NVRAM bytes to the HPS on upload, restores them on download
//                of the NVRAM index, and tracks a dirty flag for auto-save.
//                Owns port B of the 256x8 dual-port NVRAM.
//  Revision    : 1.0  initial release
// ============================================================================
module nvram_ioctl_port #(
   parameter int NV_INDEX = 4,
   parameter int NV_SIZE  = 256,
   parameter int AW       = 8
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_upload,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic [AW-1:0] nv_addr,
   output logic [7:0]    nv_wdata,
   output logic          nv_we,
   input  logic [7:0]    nv_rdata,
   input  logic          cpu_nv_we,
   output logic          busy,
   output logic          dirty
);

   localparam logic [7:0]  C_INDEX = 8'(NV_INDEX);
   localparam logic [24:0] C_SIZE  = 25'(NV_SIZE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_ADDR = 2'd1,
      S_RD_DATA = 2'd2,
      S_WR      = 2'd3
   } state_t;

   state_t        state_q;
   logic [AW-1:0] nv_addr_q;
   logic [7:0]    nv_wdata_q;
   logic          nv_we_q;
   logic [7:0]    din_q;
   logic          wait_q;
   logic          oob_q;

   logic          busy_q;
   logic          busy_prev_q;
   logic          xfer_q;
   logic          xfer_d;
   logic          dirty_q;
   logic          dirty_d;

   logic          sel;
   logic          in_range;
   logic          wr_go;
   logic          rd_go;
   logic          session_clr;

   // Only transfers tagged with the NVRAM file index concern this block.
   assign sel      = (ioctl_index == C_INDEX);
   assign in_range = (ioctl_addr < C_SIZE);

   // New requests are taken only from IDLE; strobes during a stall are
   // ignored. An in-range write preempts a simultaneous read, while an
   // out-of-range write is silently dropped and never stalls the HPS.
   assign wr_go = (state_q == S_IDLE) & ioctl_wr & ioctl_download & sel & in_range;
   assign rd_go = (state_q == S_IDLE) & ioctl_rd & ioctl_upload & sel & ~wr_go;

   // Transfer sequencer: address phase, RAM latency phase, data return or
   // single write pulse. All outputs are registered.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         nv_addr_q  <= '0;
         nv_wdata_q <= 8'h00;
         nv_we_q    <= 1'b0;
         din_q      <= 8'h00;
         wait_q     <= 1'b0;
         oob_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wr_go) begin
                  state_q    <= S_WR;
                  nv_addr_q  <= ioctl_addr[AW-1:0];
                  nv_wdata_q <= ioctl_dout;
                  nv_we_q    <= 1'b1;
                  wait_q     <= 1'b1;
               end else if (rd_go) begin
                  state_q   <= S_RD_ADDR;
                  nv_addr_q <= ioctl_addr[AW-1:0];
                  oob_q     <= ~in_range;
                  wait_q    <= 1'b1;
               end
            end
            S_RD_ADDR: begin
               // RAM registers the address this cycle; data appears next.
               state_q <= S_RD_DATA;
            end
            S_RD_DATA: begin
               // Addresses beyond the NVRAM read as erased flash (0xFF).
               din_q   <= oob_q ? 8'hFF : nv_rdata;
               wait_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_WR: begin
               nv_we_q <= 1'b0;
               wait_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               nv_we_q <= 1'b0;
               wait_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // A session that moved at least one real NVRAM byte leaves the RAM in
   // sync with the HPS copy, so its end clears dirty one cycle after busy
   // falls. CPU writes in that same cycle keep the flag set.
   assign session_clr = busy_prev_q & ~busy_q & xfer_q;

   // Next-state logic for the transfer-seen and dirty flags.
   always_comb begin
      xfer_d  = (xfer_q & ~session_clr) | wr_go | (rd_go & in_range);
      dirty_d = cpu_nv_we | (dirty_q & ~session_clr);
   end

   // Session tracking and dirty flag registers.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         busy_q      <= 1'b0;
         busy_prev_q <= 1'b0;
         xfer_q      <= 1'b0;
         dirty_q     <= 1'b0;
      end else begin
         busy_q      <= sel & (ioctl_upload | ioctl_download);
         busy_prev_q <= busy_q;
         xfer_q      <= xfer_d;
         dirty_q     <= dirty_d;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign nv_addr    = nv_addr_q;
   assign nv_wdata   = nv_wdata_q;
   assign nv_we      = nv_we_q;
   assign busy       = busy_q;
   assign dirty      = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_nvram_ioctl_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nvram_ioctl_port
//  Description : Self-checking bench for nvram_ioctl_port with a dual-port
//                RAM model, a shadow-array reference and dirty-flag model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nvram_ioctl_port;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [7:0]  nv_addr;
   logic [7:0]  nv_wdata;
   logic        nv_we;
   logic [7:0]  nv_rdata;
   logic        cpu_nv_we;
   logic        busy;
   logic        dirty;

   // CPU side (port A) of the RAM model
   logic [7:0]  pa_addr;
   logic [7:0]  pa_data;

   logic [7:0]  ram [0:255];
   int          we_cnt = 0;

   int          vectors     = 0;
   int          miscompares = 0;

   // Reference model state
   logic [7:0]  shadow [0:255];
   logic        dirty_m;
   logic        xfer_m;
   logic [7:0]  din_m;
   int          we_exp;

   nvram_ioctl_port #(.NV_INDEX(4), .NV_SIZE(256), .AW(8)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_upload   (ioctl_upload),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_rd       (ioctl_rd),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_din      (ioctl_din),
      .ioctl_wait     (ioctl_wait),
      .nv_addr        (nv_addr),
      .nv_wdata       (nv_wdata),
      .nv_we          (nv_we),
      .nv_rdata       (nv_rdata),
      .cpu_nv_we      (cpu_nv_we),
      .busy           (busy),
      .dirty          (dirty)
   );

   always #10 clk_sys = ~clk_sys;

   // Dual-port RAM model: port A from the CPU, port B registered read.
   always @(posedge clk_sys) begin
      if (cpu_nv_we) ram[pa_addr] <= pa_data;
      if (nv_we) begin
         ram[nv_addr] <= nv_wdata;
         we_cnt       <= we_cnt + 1;
      end
      nv_rdata <= ram[nv_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [24:0] a);
      return (a < 25'd256) ? shadow[a[7:0]] : 8'hFF;
   endfunction

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      pa_addr   = a;
      pa_data   = d;
      cpu_nv_we = 1'b1;
      shadow[a] = d;
      dirty_m   = 1'b1;
      @(negedge clk_sys);
      cpu_nv_we = 1'b0;
      chk("cpu_dirty", 32'(dirty), 32'(dirty_m));
   endtask

   task automatic do_read(input logic [24:0] a);
      logic [7:0] exp;
      exp        = model_read(a);
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      chk("rd_wait1", 32'(ioctl_wait), 32'd1);
      chk("rd_addr", 32'(nv_addr), 32'(a[7:0]));
      chk("rd_din_hold", 32'(ioctl_din), 32'(din_m));
      @(negedge clk_sys);
      chk("rd_wait2", 32'(ioctl_wait), 32'd1);
      @(negedge clk_sys);
      chk("rd_wait_end", 32'(ioctl_wait), 32'd0);
      chk("rd_data", 32'(ioctl_din), 32'(exp));
      din_m = exp;
      if (a < 25'd256) xfer_m = 1'b1;
   endtask

   task automatic do_write(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (a < 25'd256) begin
         chk("wr_we", 32'(nv_we), 32'd1);
         chk("wr_wait", 32'(ioctl_wait), 32'd1);
         chk("wr_addr", 32'(nv_addr), 32'(a[7:0]));
         chk("wr_data", 32'(nv_wdata), 32'(d));
         shadow[a[7:0]] = d;
         xfer_m = 1'b1;
         we_exp++;
      end else begin
         chk("wr_oob_we", 32'(nv_we), 32'd0);
         chk("wr_oob_wait", 32'(ioctl_wait), 32'd0);
      end
      @(negedge clk_sys);
      chk("wr_we_end", 32'(nv_we), 32'd0);
      chk("wr_wait_end", 32'(ioctl_wait), 32'd0);
   endtask

   task automatic start_session(input logic up, input logic down);
      ioctl_index    = 8'd4;
      ioctl_upload   = up;
      ioctl_download = down;
      @(negedge clk_sys);
      chk("busy_rise", 32'(busy), 32'd1);
   endtask

   // Ends the session; optionally lands a CPU write in the clear cycle.
   task automatic end_session(input logic cpu_hit);
      ioctl_upload   = 1'b0;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      chk("busy_fall", 32'(busy), 32'd0);
      chk("dirty_pre_clr", 32'(dirty), 32'(dirty_m));
      if (cpu_hit) begin
         pa_addr   = 8'h08;
         pa_data   = 8'($urandom);
         shadow[8'h08] = pa_data;
         cpu_nv_we = 1'b1;
      end
      if (xfer_m) dirty_m = cpu_hit;
      else        dirty_m = dirty_m | cpu_hit;
      xfer_m = 1'b0;
      @(negedge clk_sys);
      cpu_nv_we = 1'b0;
      chk("dirty_post_clr", 32'(dirty), 32'(dirty_m));
   endtask

   initial begin
      logic [24:0] a;
      reset          = 1'b1;
      ioctl_upload   = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_rd       = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = 8'h00;
      cpu_nv_we      = 1'b0;
      pa_addr        = 8'h00;
      pa_data        = 8'h00;
      dirty_m        = 1'b0;
      xfer_m         = 1'b0;
      din_m          = 8'h00;
      we_exp         = 0;

      // Fill the RAM with random contents while reset is held.
      @(negedge clk_sys);
      for (int i = 0; i < 256; i++) begin
         pa_addr   = 8'(i);
         pa_data   = 8'($urandom);
         shadow[i] = pa_data;
         cpu_nv_we = 1'b1;
         @(negedge clk_sys);
      end
      cpu_nv_we = 1'b0;
      @(negedge clk_sys);

      // Reset values
      chk("rst_din", 32'(ioctl_din), 32'd0);
      chk("rst_wait", 32'(ioctl_wait), 32'd0);
      chk("rst_nv_addr", 32'(nv_addr), 32'd0);
      chk("rst_nv_wdata", 32'(nv_wdata), 32'd0);
      chk("rst_nv_we", 32'(nv_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dirty", 32'(dirty), 32'd0);
      reset = 1'b0;
      @(negedge clk_sys);

      // Foreign index is ignored entirely.
      ioctl_index  = 8'd0;
      ioctl_upload = 1'b1;
      ioctl_addr   = 25'h033;
      ioctl_rd     = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      chk("idx0_wait", 32'(ioctl_wait), 32'd0);
      chk("idx0_nv_addr", 32'(nv_addr), 32'd0);
      chk("idx0_busy", 32'(busy), 32'd0);
      @(negedge clk_sys);
      chk("idx0_wait2", 32'(ioctl_wait), 32'd0);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);

      // CPU write marks NVRAM dirty.
      cpu_write(8'h10, 8'h5A);

      // Upload session: directed and random reads.
      start_session(1'b1, 1'b0);
      do_read(25'h010);
      chk("rd_5a", 32'(ioctl_din), 32'h5A);
      do_read(25'h100);
      chk("rd_oob_ff", 32'(ioctl_din), 32'hFF);
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, 255));
         do_read(a);
      end
      chk("rd_no_we", 32'(we_cnt), 32'(we_exp));
      end_session(1'b0);

      // Download session: directed and random writes.
      cpu_write(8'h05, 8'($urandom));
      start_session(1'b0, 1'b1);
      do_write(25'h020, 8'hC3);
      do_write(25'h120, 8'h11);
      for (int i = 0; i < 24; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'($urandom_range(0, 255));
         do_write(a, 8'($urandom));
      end
      chk("wr_count", 32'(we_cnt), 32'(we_exp));
      end_session(1'b0);

      // Full 256-byte upload clears dirty.
      cpu_write(8'h07, 8'($urandom));
      start_session(1'b1, 1'b0);
      for (int i = 0; i < 256; i++) do_read(25'(i));
      end_session(1'b0);
      chk("full_clr", 32'(dirty), 32'd0);

      // CPU write coinciding with the clear keeps dirty set.
      start_session(1'b1, 1'b0);
      do_read(25'($urandom_range(0, 255)));
      end_session(1'b1);
      chk("set_wins", 32'(dirty), 32'd1);

      // Session with no transfers leaves dirty alone.
      start_session(1'b1, 1'b0);
      @(negedge clk_sys);
      end_session(1'b0);
      chk("empty_sess", 32'(dirty), 32'd1);

      // Simultaneous rd and wr: the write wins, data return untouched.
      start_session(1'b1, 1'b1);
      ioctl_addr = 25'h040;
      ioctl_dout = 8'h77;
      ioctl_rd   = 1'b1;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      ioctl_wr = 1'b0;
      chk("both_we", 32'(nv_we), 32'd1);
      shadow[8'h40] = 8'h77;
      xfer_m = 1'b1;
      we_exp++;
      @(negedge clk_sys);
      @(negedge clk_sys);
      chk("both_din", 32'(ioctl_din), 32'(din_m));
      do_read(25'h040);
      end_session(1'b0);

      // Reset during WR aborts the pending write.
      start_session(1'b0, 1'b1);
      ioctl_addr = 25'h030;
      ioctl_dout = ~shadow[8'h30];
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk("rst_wr_we_before", 32'(nv_we), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_wr_we_drop", 32'(nv_we), 32'd0);
      chk("rst_wr_wait", 32'(ioctl_wait), 32'd0);
      @(negedge clk_sys);
      reset          = 1'b0;
      dirty_m        = 1'b0;
      xfer_m         = 1'b0;
      din_m          = 8'h00;
      ioctl_download = 1'b0;
      ioctl_upload   = 1'b1;
      @(negedge clk_sys);
      do_read(25'h030);
      chk("rst_no_write", 32'(we_cnt), 32'(we_exp));
      end_session(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
